onchip_mem_copy_master: RTL and testbench

//  Avalon-MM master engine that drives the single-port on-chip RAM slave (32-bit, word-addressed, 1-cycle read latency).

---
 rtl/onchip_mem_copy_master.sv | 179 +++++++++++++++++
 tb/tb_onchip_mem_copy_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master that copies or fills a block of words in the on-chip RAM.
// One word in flight at a time; all bus outputs are registered.
module onchip_mem_copy_master #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 20480,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  input  logic [DATA_W-1:0]   pattern,
  input  logic                abort,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy,
  output logic                done,
  output logic                err_range,
  output logic [ADDR_W:0]     words_done,
  output logic [DATA_W-1:0]   checksum
);

  localparam int XW = ADDR_W + 2;

  typedef enum logic [2:0] {
    IDLE, CHECK, RD, WAIT, WR, FIN
  } state_t;

  state_t              state;
  logic                mode_r;
  logic [ADDR_W-1:0]   src_cur;
  logic [ADDR_W-1:0]   dst_cur;
  logic [ADDR_W:0]     len_r;
  logic [DATA_W-1:0]   pattern_r;
  logic [2:0]          wait_cnt;
  logic [ADDR_W:0]     words_nxt;
  logic [XW-1:0]       src_x;
  logic [XW-1:0]       dst_x;
  logic [XW-1:0]       src_end;
  logic [XW-1:0]       dst_end;
  logic                range_bad;

  assign byteenable = '1;
  assign clken      = 1'b1;
  assign words_nxt  = words_done + (ADDR_W+1)'(1);

  // Forward copy is only unsafe when dst lands inside the source block
  always_comb begin
    src_x     = XW'(src_cur);
    dst_x     = XW'(dst_cur);
    src_end   = src_x + XW'(len_r);
    dst_end   = dst_x + XW'(len_r);
    range_bad = dst_end > XW'(DEPTH);
    if (!mode_r) begin
      if (src_end > XW'(DEPTH))
        range_bad = 1'b1;
      if (src_x < dst_x && dst_x < src_end)
        range_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mode_r     <= 1'b0;
      src_cur    <= '0;
      dst_cur    <= '0;
      len_r      <= '0;
      pattern_r  <= '0;
      wait_cnt   <= '0;
      address    <= '0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_range  <= 1'b0;
      words_done <= '0;
      checksum   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_r     <= mode;
            src_cur    <= src_addr;
            dst_cur    <= dst_addr;
            len_r      <= len;
            pattern_r  <= pattern;
            err_range  <= 1'b0;
            words_done <= '0;
            checksum   <= '0;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (range_bad || len_r == '0) begin
            err_range <= range_bad;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end else if (mode_r) begin
            chipselect <= 1'b1;
            write      <= 1'b1;
            address    <= dst_cur;
            writedata  <= pattern_r;
            state      <= WR;
          end else begin
            chipselect <= 1'b1;
            address    <= src_cur;
            state      <= RD;
          end
        end
        RD: begin
          chipselect <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            wait_cnt <= 3'(READ_LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else if (wait_cnt == '0) begin
            writedata  <= readdata;
            chipselect <= 1'b1;
            write      <= 1'b1;
            address    <= dst_cur;
            state      <= WR;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        WR: begin
          words_done <= words_nxt;
          checksum   <= checksum + writedata;
          src_cur    <= src_cur + ADDR_W'(1);
          dst_cur    <= dst_cur + ADDR_W'(1);
          if (words_nxt == len_r || abort) begin
            chipselect <= 1'b0;
            write      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= FIN;
          end else if (mode_r) begin
            address <= dst_cur + ADDR_W'(1);
          end else begin
            write   <= 1'b0;
            address <= src_cur + ADDR_W'(1);
            state   <= RD;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Bench for onchip_mem_copy_master: RAM slave model plus a block-level
// reference of expected memory, counts, checksum and done latency.
module tb_onchip_mem_copy_master;

  localparam int DEPTH = 20480;
  localparam int RL    = 1;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [14:0] src_addr;
  logic [14:0] dst_addr;
  logic [15:0] len;
  logic [31:0] pattern;
  logic        abort;
  logic [14:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic [31:0] readdata;
  logic        busy;
  logic        done;
  logic        err_range;
  logic [15:0] words_done;
  logic [31:0] checksum;

  int checks   = 0;
  int errors   = 0;
  int cs_total = 0;
  bit mem_ready = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] exp_mem [DEPTH];

  onchip_mem_copy_master #(
    .ADDR_W(15), .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .pattern(pattern), .abort(abort), .address(address),
    .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .clken(clken),
    .readdata(readdata), .busy(busy), .done(done),
    .err_range(err_range), .words_done(words_done),
    .checksum(checksum)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] seed_word(input int i);
    if (i >= 'h100 && i < 'h103)
      return 32'(i - 'hff);
    return (32'(i) * 32'h9e3779b1) ^ 32'h13572468;
  endfunction

  // RAM slave: 1-cycle read latency
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = seed_word(i);
      mem_ready = 1;
    end
    if (chipselect) cs_total++;
    if (chipselect && write && int'(address) < DEPTH)
      mem[address] = writedata;
    if (chipselect && !write && int'(address) < DEPTH)
      readdata <= mem[address];
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_cmp(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== exp_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic xfer(input bit m, input int src, input int dst,
                      input int ln, input logic [31:0] pat,
                      input int abort_at);
    bit          err;
    int          n;
    int          lat;
    int          wr_seen;
    int          cs_base;
    int          cs_exp;
    logic [31:0] sum;
    logic [31:0] v;
    err = (dst + ln > DEPTH);
    if (!m && (src + ln > DEPTH || (src < dst && dst < src + ln)))
      err = 1;
    n = err ? 0 : ln;
    if (abort_at > 0 && abort_at < n) n = abort_at;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      v = m ? pat : exp_mem[src + i];
      exp_mem[dst + i] = v;
      sum += v;
    end
    cs_exp = m ? n : 2 * n;
    if (err || ln == 0) lat = 2;
    else lat = 2 + n * (m ? 1 : 2 + RL);

    cs_base  = cs_total;
    start    = 1;
    mode     = m;
    src_addr = 15'(src);
    dst_addr = 15'(dst);
    len      = 16'(ln);
    pattern  = pat;
    @(negedge clk);
    start = 0;
    wr_seen = 0;
    begin
      int got;
      got = -1;
      for (int k = 1; k <= 500 && got < 0; k++) begin
        if (k > 1) @(negedge clk);
        abort = 0;
        if (k == 1) chk("busy_c1", busy, 1);
        if (write) begin
          wr_seen++;
          if (abort_at > 0 && wr_seen == abort_at) abort = 1;
        end
        if (done) got = k;
      end
      abort = 0;
      if (got < 0) begin
        chk("timeout", 0, 1);
        return;
      end
      chk("latency", got, lat);
    end
    chk("busy_at_done", busy, 0);
    chk("err_range", err_range, err);
    chk("words_done", words_done, n);
    chk("checksum", checksum, sum);
    chk("cs_cycles", cs_total - cs_base, cs_exp);
    mem_cmp("mem");
    @(negedge clk);
    chk("done_1cyc", done, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_wdata"}, writedata, 0);
    chk({tag, "_cs"}, chipselect, 0);
    chk({tag, "_wr"}, write, 0);
    chk({tag, "_be"}, byteenable, 4'hf);
    chk({tag, "_clken"}, clken, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_range, 0);
    chk({tag, "_words"}, words_done, 0);
    chk({tag, "_csum"}, checksum, 0);
  endtask

  initial begin
    int s, m, ln, src, dst, ab, rd_seen;
    reset = 1; start = 0; mode = 0; abort = 0;
    src_addr = 0; dst_addr = 0; len = 0; pattern = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = seed_word(i);
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 0;
    @(negedge clk);

    xfer(1, 0, 'h10, 4, 32'ha5a5_0001, 0);
    chk("fill_csum_const", checksum, 32'h9694_0004);
    xfer(0, 'h100, 'h200, 3, 0, 0);
    chk("copy_w0", mem['h200], 1);
    chk("copy_w2", mem['h202], 3);
    xfer(0, 'h40, 'h80, 0, 0, 0);
    xfer(1, 0, 'h80, 0, 32'h1234, 0);
    xfer(0, 'h10, 'h12, 4, 0, 0);
    xfer(1, 0, 20478, 3, 32'hdead_beef, 0);
    xfer(1, 0, 'h500, 10, 32'h0bad_f00d, 4);
    xfer(1, 0, 20477, 3, 32'h7777_0000, 0);
    xfer(0, 'h20, 'h10, 6, 0, 0);

    for (int t = 0; t < 30; t++) begin
      s  = $urandom_range(0, 3);
      m  = $urandom_range(0, 1);
      ln = $urandom_range(0, 12);
      src = $urandom_range(0, DEPTH - 1);
      dst = $urandom_range(0, DEPTH - 1);
      if (s == 1) dst = DEPTH - $urandom_range(1, 14);
      if (s == 2) begin
        src = $urandom_range(0, DEPTH - 20);
        dst = src + $urandom_range(0, 14);
      end
      if (s == 3) begin
        src = DEPTH - $urandom_range(1, 14);
        dst = $urandom_range(0, DEPTH - 20);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      xfer(m[0], src, dst, ln, $urandom, ab);
    end

    // Reset in the WAIT of the 3rd word of an 8-word copy
    start = 1; mode = 0;
    src_addr = 15'h300; dst_addr = 15'h400; len = 16'd8;
    @(negedge clk);
    start = 0;
    rd_seen = 0;
    for (int k = 0; k < 100 && rd_seen < 3; k++) begin
      @(negedge clk);
      if (chipselect && !write) rd_seen++;
    end
    chk("rd_seen", rd_seen, 3);
    @(negedge clk);
    reset = 1;
    #1;
    check_reset_vals("midrst");
    for (int i = 0; i < 2; i++) exp_mem['h400 + i] = exp_mem['h300 + i];
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("idle_cs", chipselect, 0);
    mem_cmp("mem_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
